cache_fill_ctrl: RTL and testbench
==================================

CACHE_FILL_CTRL -- requirements
Module: cache_fill_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 64, is the maximum number of cycles to wait for memAck on one memory beat.
REQ-002 clk  in  1  Single clock; all state updates occur on its rising edge.
REQ-003 reset  in  1  Asynchronous, active-low reset.
REQ-004 memRead, memWrite  in  1 each  CPU data-side load and store requests, held high until stall is low.
REQ-005 AdrD  in  32  CPU byte address; writeDataD  in  32  CPU store data.
REQ-006 hit  in  1  Cache hit indication for AdrD.
REQ-007 stall  out  1  Freezes the CPU while a request is being serviced.
REQ-008 memReq  out  1  Main-memory request; memWe  out  1  write enable; memAdr  out  32  word address; memWdata  out  32  write data.
REQ-009 memAck  in  1  One-cycle beat acknowledge; memRdata  in  32  read data, valid with memAck.
REQ-010 writeM  out  1  Line-fill strobe to the cache; writeAdrM  out  32  line address.
REQ-011 writeDataM0..writeDataM15  out  32 each  Fill-line words; word i is at line address + 4*i.
REQ-012 err  out  1  Sticky memory-timeout flag.

Function
REQ-013 States: IDLE, FILL, COMMIT, WT, WDONE.
REQ-014 IDLE: stall = (memRead|memWrite) & ~hit; on that condition, latch lineAdr = {AdrD[31:6], 6'b0}, clear beat counter (4 bits) and go to FILL.
REQ-015 FILL: memReq=1, memWe=0, memAdr = lineAdr + 4*beat, stall=1.
REQ-016 FILL: on memAck, buf[beat] <= memRdata and beat increments; on the ack with beat==15, go to COMMIT; no address wrap beyond the line.
REQ-017 COMMIT: writeM=1 for exactly one cycle; writeAdrM = lineAdr; writeDataMi = buf[i]; stall=1; next state IDLE.
REQ-018 writeM SHALL be 0 in every state except COMMIT; writeDataM*/writeAdrM hold their last values.
REQ-019 A miss is serviced in 16 acked beats + 1 commit cycle; the minimum miss penalty is 18 cycles, including the IDLE re-check in which hit rises and stall falls.
REQ-020 Timeout counter clears on entry to FILL or WT and on each memAck; when it reaches TIMEOUT-1 without an ack, set err=1, drop memReq and go to IDLE without asserting writeM.
REQ-021 err SHALL be cleared only by reset; after a timeout, a still-pending miss starts a fresh FILL.
REQ-022 memAck in IDLE, COMMIT or WDONE SHALL be ignored.
REQ-023 When memRead and memWrite are both high, the request is treated as a write.

Reset
REQ-024 When reset=0: state=IDLE, beat=0, timeout counter=0, err=0, memReq=0, memWe=0, memAdr=0, memWdata=0, writeM=0, writeAdrM=0, all writeDataM*=0.
REQ-025 Reset mid-FILL or mid-WT SHALL abort immediately; no writeM is issued for the partial line.

Configuration
REQ-026 Macro CACHE_WRITE_THROUGH_EN: when defined, a memWrite with hit=1 in IDLE holds stall=1 and enters WT.
REQ-027 WT: memReq=1, memWe=1, memAdr = AdrD, memWdata = writeDataD; on memAck go to WDONE (stall=0 for one cycle), then IDLE.
REQ-028 When CACHE_WRITE_THROUGH_EN is undefined, WT and WDONE are absent, memWe is constant 0, and a write hit gives stall=0 in IDLE (write-back to cache only).
REQ-029 Write misses allocate in both builds: FILL, COMMIT, then handling as a write hit.

Verification
REQ-030 memRead=1, AdrD=0x0000_1044, hit=0; memory acks every cycle with memRdata=beat index -> memAdr 0x1040..0x107C; writeM pulses on cycle 17 with writeAdrM=0x1040 and writeDataM15=15; stall falls once hit=1.
REQ-031 Same fill, but memAck withheld on beat 5 for TIMEOUT cycles -> err=1, memReq=0, state IDLE, no writeM pulse; the next ack-driven fill completes normally and err stays 1.
REQ-032 reset pulsed low during beat 9 -> all outputs 0 within that cycle; after release with hit=0, the fill restarts at beat 0.
REQ-033 With CACHE_WRITE_THROUGH_EN: memWrite=1, hit=1, AdrD=0x2008, writeDataD=0xDEADBEEF, ack after 3 cycles -> memWe=1, memAdr=0x2008, memWdata=0xDEADBEEF; stall is low for exactly one cycle in WDONE.
REQ-034 Without the macro: same write hit -> stall=0, memReq=0. Write miss -> a fill occurs, and memWe stays 0 throughout.

Source files
------------

// File: rtl/cache_fill_ctrl.sv
// -----------------------------------------------------------------------------
// cache_fill_ctrl
//
// Data-cache miss controller. On a load/store miss it stalls the CPU, fetches
// the 64-byte line from main memory as 16 acknowledged word beats, then
// presents the whole line to the cache with a one-cycle writeM strobe. A beat
// that is not acknowledged within TIMEOUT cycles aborts the fill and sets a
// sticky err flag.
//
// Optional feature (macro CACHE_WRITE_THROUGH_EN): write hits are also written
// through to main memory (states WT/WDONE). Without the macro, write hits go to
// the cache only and memWe is constant 0.
//
// Ports
//   clk, reset            clock, asynchronous active-low reset
//   memRead, memWrite     CPU load / store request (held until stall is low)
//   AdrD, writeDataD      CPU byte address / store data
//   hit                   cache hit indication for AdrD
//   stall                 freezes the CPU while a request is serviced
//   memReq, memWe         memory request / write enable
//   memAdr, memWdata      memory word address / write data
//   memAck, memRdata      one-cycle beat acknowledge / read data
//   writeM, writeAdrM     line-fill strobe / line address to the cache
//   writeDataM0..15       fill-line words (word i at writeAdrM + 4*i)
//   err                   sticky memory-timeout flag
// -----------------------------------------------------------------------------
module cache_fill_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [31:0] AdrD,
  input  logic [31:0] writeDataD,
  input  logic        hit,
  output logic        stall,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAdr,
  output logic [31:0] memWdata,
  input  logic        memAck,
  input  logic [31:0] memRdata,
  output logic        writeM,
  output logic [31:0] writeAdrM,
  output logic [31:0] writeDataM0,
  output logic [31:0] writeDataM1,
  output logic [31:0] writeDataM2,
  output logic [31:0] writeDataM3,
  output logic [31:0] writeDataM4,
  output logic [31:0] writeDataM5,
  output logic [31:0] writeDataM6,
  output logic [31:0] writeDataM7,
  output logic [31:0] writeDataM8,
  output logic [31:0] writeDataM9,
  output logic [31:0] writeDataM10,
  output logic [31:0] writeDataM11,
  output logic [31:0] writeDataM12,
  output logic [31:0] writeDataM13,
  output logic [31:0] writeDataM14,
  output logic [31:0] writeDataM15,
  output logic        err
);

  localparam int              TO_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_COMMIT
`ifdef CACHE_WRITE_THROUGH_EN
    ,
    S_WT,
    S_WDONE
`endif
  } state_e;

  state_e             state_q,    state_d;
  logic [25:0]        line_adr_q, line_adr_d;  // line address bits [31:6]
  logic [3:0]         beat_q,     beat_d;
  logic [TO_W-1:0]    to_cnt_q,   to_cnt_d;
  logic               err_q,      err_d;
  logic [31:0]        wr_adr_q,   wr_adr_d;
  logic [15:0][31:0]  wr_data_q,  wr_data_d;
  logic [15:0][31:0]  fill_buf_q;
  logic               fill_we;

`ifndef CACHE_WRITE_THROUGH_EN
  // Store data and the byte offset only matter for write-through.
  logic unused_wt_inputs;
  assign unused_wt_inputs = ^{writeDataD, AdrD[5:0]};
`endif

  // NOTE: every output of this block gets a default first so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    line_adr_d = line_adr_q;
    beat_d     = beat_q;
    to_cnt_d   = '0;          // cleared in every state that is not waiting
    err_d      = err_q;
    wr_adr_d   = wr_adr_q;
    wr_data_d  = wr_data_q;
    fill_we    = 1'b0;
    stall      = 1'b0;
    memReq     = 1'b0;
    memWe      = 1'b0;
    memAdr     = '0;
    memWdata   = '0;
    writeM     = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A miss takes priority; a write miss allocates first and is then
        // handled as a write hit when it is re-checked here.
        if ((memRead || memWrite) && !hit) begin
          stall      = 1'b1;
          line_adr_d = AdrD[31:6];
          beat_d     = '0;
          state_d    = S_FILL;
        end
`ifdef CACHE_WRITE_THROUGH_EN
        else if (memWrite && hit) begin
          stall   = 1'b1;
          state_d = S_WT;
        end
`endif
      end

      S_FILL: begin
        stall  = 1'b1;
        memReq = 1'b1;
        memAdr = {line_adr_q, beat_q, 2'b00};
        if (memAck) begin
          fill_we = 1'b1;
          beat_d  = beat_q + 4'd1;
          if (beat_q == 4'd15) begin
            // Last word bypasses the buffer so the line is complete in COMMIT.
            wr_adr_d      = {line_adr_q, 6'b0};
            wr_data_d     = fill_buf_q;
            wr_data_d[15] = memRdata;
            state_d       = S_COMMIT;
          end
        end else if (to_cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      S_COMMIT: begin
        stall   = 1'b1;
        writeM  = 1'b1;
        state_d = S_IDLE;
      end

`ifdef CACHE_WRITE_THROUGH_EN
      S_WT: begin
        stall    = 1'b1;
        memReq   = 1'b1;
        memWe    = 1'b1;
        memAdr   = AdrD;
        memWdata = writeDataD;
        if (memAck) begin
          state_d = S_WDONE;
        end else if (to_cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      S_WDONE: begin
        // Releases the CPU for one cycle so it can retire the store.
        state_d = S_IDLE;
      end
`endif

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      line_adr_q <= '0;
      beat_q     <= '0;
      to_cnt_q   <= '0;
      err_q      <= 1'b0;
      wr_adr_q   <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      line_adr_q <= line_adr_d;
      beat_q     <= beat_d;
      to_cnt_q   <= to_cnt_d;
      err_q      <= err_d;
      wr_adr_q   <= wr_adr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // NOTE: the fill buffer has no reset; every word is rewritten by a complete
  // fill before it is copied to the outputs, and aborted fills are never used.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      fill_buf_q[beat_q] <= memRdata;
    end
  end

  assign err          = err_q;
  assign writeAdrM    = wr_adr_q;
  assign writeDataM0  = wr_data_q[0];
  assign writeDataM1  = wr_data_q[1];
  assign writeDataM2  = wr_data_q[2];
  assign writeDataM3  = wr_data_q[3];
  assign writeDataM4  = wr_data_q[4];
  assign writeDataM5  = wr_data_q[5];
  assign writeDataM6  = wr_data_q[6];
  assign writeDataM7  = wr_data_q[7];
  assign writeDataM8  = wr_data_q[8];
  assign writeDataM9  = wr_data_q[9];
  assign writeDataM10 = wr_data_q[10];
  assign writeDataM11 = wr_data_q[11];
  assign writeDataM12 = wr_data_q[12];
  assign writeDataM13 = wr_data_q[13];
  assign writeDataM14 = wr_data_q[14];
  assign writeDataM15 = wr_data_q[15];

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cache_fill_ctrl
//
// Self-checking bench for cache_fill_ctrl. A behavioural memory responder
// serves misses with random data and random ack gaps; the expected line
// contents, beat addresses and strobe timing are derived from what the
// responder sent. Inputs are driven and outputs sampled at the falling edge.
// -----------------------------------------------------------------------------
module tb_cache_fill_ctrl;

  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memRead = 1'b0, memWrite = 1'b0, hit = 1'b0, memAck = 1'b0;
  logic [31:0] AdrD = '0, writeDataD = '0, memRdata = '0;
  logic        stall, memReq, memWe, writeM, err;
  logic [31:0] memAdr, memWdata, writeAdrM;
  logic [31:0] wdm [16];

  int n_checks = 0;
  int n_fail   = 0;

  // Observations gathered by the memory responder.
  logic [31:0] obs_adr[$];
  logic [31:0] sent_data[$];
  logic [31:0] cap_data[16];
  logic [31:0] cap_adr;
  int writem_cnt, writem_at, release_at, gap_cycles, wait_on_beat;
  int timeouts, memwe_cycles;

  always #5 clk = ~clk;

  cache_fill_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .memRead(memRead), .memWrite(memWrite), .AdrD(AdrD),
    .writeDataD(writeDataD), .hit(hit), .stall(stall),
    .memReq(memReq), .memWe(memWe), .memAdr(memAdr), .memWdata(memWdata),
    .memAck(memAck), .memRdata(memRdata),
    .writeM(writeM), .writeAdrM(writeAdrM),
    .writeDataM0(wdm[0]),   .writeDataM1(wdm[1]),   .writeDataM2(wdm[2]),
    .writeDataM3(wdm[3]),   .writeDataM4(wdm[4]),   .writeDataM5(wdm[5]),
    .writeDataM6(wdm[6]),   .writeDataM7(wdm[7]),   .writeDataM8(wdm[8]),
    .writeDataM9(wdm[9]),   .writeDataM10(wdm[10]), .writeDataM11(wdm[11]),
    .writeDataM12(wdm[12]), .writeDataM13(wdm[13]), .writeDataM14(wdm[14]),
    .writeDataM15(wdm[15]),
    .err(err)
  );

  // Memory responder / CPU model for one miss. Presents the request, acks
  // fill beats after random gaps (or withholds one beat forever), raises hit
  // once the line was committed, and stops when stall falls.
  task automatic serve_miss(input logic [31:0] adr, input bit wr,
                            input int max_gap, input int withhold_beat,
                            input bit idx_data, input int budget);
    int  beat = 0;
    int  hold = withhold_beat;
    int  gap;
    bit  seen_req = 1'b0;
    obs_adr.delete();
    sent_data.delete();
    writem_cnt = 0; writem_at = -1; release_at = -1; gap_cycles = 0;
    wait_on_beat = 0; timeouts = 0; memwe_cycles = 0;
    gap = $urandom_range(0, max_gap);
    @(negedge clk);
    memRead = !wr; memWrite = wr; AdrD = adr; writeDataD = $urandom;
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (cyc > 0) @(negedge clk);
      memAck = 1'b0;
      hit    = (writem_cnt > 0);
      #1;
      if (memReq && memWe) begin
        memwe_cycles++;
        memAck = 1'b1;
      end else if (memReq) begin
        seen_req = 1'b1;
        if (beat == hold) begin
          wait_on_beat++;
        end else if (gap > 0) begin
          gap--;
          gap_cycles++;
        end else begin
          memAck   = 1'b1;
          memRdata = idx_data ? 32'(beat) : $urandom;
          sent_data.push_back(memRdata);
          obs_adr.push_back(memAdr);
          beat++;
          gap = $urandom_range(0, max_gap);
        end
      end else if (stall && seen_req && beat < 16) begin
        // Fill abandoned: the pending miss must restart from word 0.
        timeouts++;
        seen_req = 1'b0;
        beat = 0;
        hold = -1;
        sent_data.delete();
        obs_adr.delete();
      end
      #1;
      if (writeM) begin
        writem_cnt++;
        writem_at = cyc;
        cap_adr   = writeAdrM;
        for (int i = 0; i < 16; i++) cap_data[i] = wdm[i];
      end
      if (!stall) begin
        release_at = cyc;
        break;
      end
    end
    memRead = 1'b0; memWrite = 1'b0; memAck = 1'b0; hit = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({stall, memReq, memWe, writeM, err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got stall/req/we/writeM/err=%b expected 00000",
               {stall, memReq, memWe, writeM, err});
    end
    n_checks++;
    if ({memAdr, memWdata, writeAdrM} !== 96'b0) begin
      n_fail++;
      $display("FAIL reset_adr: got memAdr=%h memWdata=%h writeAdrM=%h expected 0",
               memAdr, memWdata, writeAdrM);
    end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (wdm[i] !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_wdata%0d: got %h expected 0", i, wdm[i]);
      end
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Generic check of a completed (non-aborted) fill against the model.
  task automatic check_fill(input string tag, input logic [31:0] adr,
                            input int exp_writem_at, input int exp_release_at,
                            input int exp_memwe);
    logic [31:0] line;
    line = adr & 32'hFFFF_FFC0;
    n_checks++;
    if (writem_cnt !== 1 || writem_at !== exp_writem_at) begin
      n_fail++;
      $display("FAIL %s_writem: got %0d pulses at cycle %0d expected 1 at %0d",
               tag, writem_cnt, writem_at, exp_writem_at);
    end
    n_checks++;
    if (cap_adr !== line) begin
      n_fail++;
      $display("FAIL %s_line_adr: got %h expected %h", tag, cap_adr, line);
    end
    n_checks++;
    if (obs_adr.size() !== 16) begin
      n_fail++;
      $display("FAIL %s_beats: got %0d beats expected 16", tag, obs_adr.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        n_checks++;
        if (obs_adr[i] !== line + 32'(4 * i)) begin
          n_fail++;
          $display("FAIL %s_memadr%0d: got %h expected %h", tag, i, obs_adr[i],
                   line + 32'(4 * i));
        end
        n_checks++;
        if (cap_data[i] !== sent_data[i]) begin
          n_fail++;
          $display("FAIL %s_word%0d: got %h expected %h", tag, i, cap_data[i],
                   sent_data[i]);
        end
      end
    end
    n_checks++;
    if (release_at !== exp_release_at) begin
      n_fail++;
      $display("FAIL %s_release: got stall low at cycle %0d expected %0d",
               tag, release_at, exp_release_at);
    end
    n_checks++;
    if (memwe_cycles !== exp_memwe) begin
      n_fail++;
      $display("FAIL %s_memwe: got %0d write cycles expected %0d",
               tag, memwe_cycles, exp_memwe);
    end
  endtask

  task automatic test_fill_example();
    serve_miss(32'h0000_1044, 1'b0, 0, -1, 1'b1, 200);
    check_fill("ex", 32'h0000_1044, 17, 18, 0);
    n_checks++;
    if (cap_data[15] !== 32'd15) begin
      n_fail++;
      $display("FAIL ex_word15: got %h expected 0000000f", cap_data[15]);
    end
    @(negedge clk); #1;
    n_checks++;
    if (writeM !== 1'b0 || wdm[15] !== 32'd15 || writeAdrM !== 32'h1040) begin
      n_fail++;
      $display("FAIL ex_hold: got writeM=%b word15=%h adr=%h expected 0/0000000f/00001040",
               writeM, wdm[15], writeAdrM);
    end
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL ex_err: got %b expected 0", err);
    end
  endtask

  task automatic test_random_fills();
    for (int n = 0; n < 5; n++) begin
      logic [31:0] adr;
      bit          wr;
      int          exp_rel, exp_we;
      adr = $urandom;
      wr  = 1'($urandom_range(0, 1));
`ifdef CACHE_WRITE_THROUGH_EN
      exp_rel = wr ? 3 : 1;
      exp_we  = wr ? 1 : 0;
`else
      exp_rel = 1;
      exp_we  = 0;
`endif
      serve_miss(adr, wr, 3, -1, 1'b0, 400);
      check_fill(wr ? "rnd_wr" : "rnd_rd", adr, 17 + gap_cycles,
                 17 + gap_cycles + exp_rel, exp_we);
    end
  endtask

  task automatic test_write_hit();
`ifdef CACHE_WRITE_THROUGH_EN
    int stalled = 0;
    bit released = 1'b0;
    @(negedge clk);
    memWrite = 1'b1; hit = 1'b1; AdrD = 32'h2008; writeDataD = 32'hDEADBEEF;
    for (int cyc = 0; cyc < 20 && !released; cyc++) begin
      if (cyc > 0) @(negedge clk);
      memAck = (cyc == 3);
      #1;
      if (cyc >= 1 && cyc <= 3) begin
        n_checks++;
        if ({memReq, memWe} !== 2'b11 || memAdr !== 32'h2008 ||
            memWdata !== 32'hDEADBEEF) begin
          n_fail++;
          $display("FAIL wt_bus: got req/we=%b adr=%h data=%h expected 11/00002008/deadbeef",
                   {memReq, memWe}, memAdr, memWdata);
        end
      end
      if (stall) stalled++;
      else released = 1'b1;
    end
    n_checks++;
    if (stalled !== 4 || !released) begin
      n_fail++;
      $display("FAIL wt_stall: got %0d stall cycles expected 4 then release", stalled);
    end
    memWrite = 1'b0; memAck = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if (stall !== 1'b0 || memReq !== 1'b0) begin
      n_fail++;
      $display("FAIL wt_idle: got stall=%b memReq=%b expected 0/0", stall, memReq);
    end
`else
    @(negedge clk);
    memWrite = 1'b1; hit = 1'b1; AdrD = $urandom; writeDataD = $urandom;
    for (int cyc = 0; cyc < 3; cyc++) begin
      if (cyc > 0) @(negedge clk);
      memAck = 1'($urandom_range(0, 1));
      #1;
      n_checks++;
      if ({stall, memReq, memWe} !== 3'b000) begin
        n_fail++;
        $display("FAIL wb_hit: got stall/req/we=%b expected 000",
                 {stall, memReq, memWe});
      end
    end
    memWrite = 1'b0; hit = 1'b0; memAck = 1'b0;
`endif
  endtask

  task automatic test_timeout();
    logic [31:0] adr;
    adr = $urandom;
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL to_err_before: got %b expected 0", err);
    end
    serve_miss(adr, 1'b0, 0, 5, 1'b0, 400);
    n_checks++;
    if (timeouts !== 1 || wait_on_beat !== TIMEOUT) begin
      n_fail++;
      $display("FAIL to_abort: got %0d aborts after %0d wait cycles expected 1 after %0d",
               timeouts, wait_on_beat, TIMEOUT);
    end
    // 1 request cycle + 5 acked beats + TIMEOUT waits + 1 re-check, then a
    // fresh 16-beat fill; the single writeM belongs to the fresh fill.
    check_fill("to", adr, 17 + 5 + TIMEOUT + 1, 17 + 5 + TIMEOUT + 2, 0);
    @(negedge clk); #1;
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL to_err_sticky: got %b expected 1", err);
    end
  endtask

  task automatic test_reset_mid_fill();
    logic [31:0] adr;
    int acks = 0;
    adr = $urandom;
    @(negedge clk);
    memRead = 1'b1; hit = 1'b0; AdrD = adr;
    for (int cyc = 0; cyc < 40 && acks < 9; cyc++) begin
      if (cyc > 0) @(negedge clk);
      #1;
      memAck = memReq;
      memRdata = $urandom;
      if (memReq) acks++;
    end
    @(negedge clk); #1;
    memAck = 1'b0;
    n_checks++;
    if (memReq !== 1'b1 || memAdr !== (adr & 32'hFFFF_FFC0) + 32'd36) begin
      n_fail++;
      $display("FAIL rst_beat9: got memReq=%b memAdr=%h expected 1/%h",
               memReq, memAdr, (adr & 32'hFFFF_FFC0) + 32'd36);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if ({memReq, memWe, writeM, err} !== 4'b0 || memAdr !== 32'h0 ||
        memWdata !== 32'h0 || writeAdrM !== 32'h0 || wdm[0] !== 32'h0 ||
        wdm[15] !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_mid: got req/we/writeM/err=%b adr=%h wadr=%h w0=%h w15=%h expected all 0",
               {memReq, memWe, writeM, err}, memAdr, writeAdrM, wdm[0], wdm[15]);
    end
    memRead = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    serve_miss(adr, 1'b0, 2, -1, 1'b0, 300);
    check_fill("rst", adr, 17 + gap_cycles, 18 + gap_cycles, 0);
  endtask

  task automatic test_ignored_ack();
    logic [31:0] held;
    held = wdm[7];
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      memAck = 1'b1;
      memRdata = $urandom;
      #1;
      n_checks++;
      if ({stall, memReq, writeM} !== 3'b000 || wdm[7] !== held) begin
        n_fail++;
        $display("FAIL idle_ack: got stall/req/writeM=%b word7=%h expected 000/%h",
                 {stall, memReq, writeM}, wdm[7], held);
      end
    end
    memAck = 1'b0;
    serve_miss($urandom, 1'b0, 1, -1, 1'b0, 300);
    check_fill("post_ack", AdrD, 17 + gap_cycles, 18 + gap_cycles, 0);
  endtask

  initial begin
    test_reset();
    test_fill_example();
    test_random_fills();
    test_write_hit();
    test_ignored_ack();
    test_timeout();
    test_reset_mid_fill();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
